// File: rtl/wb_stage_buf.sv
// wb_stage_buf: LA32 writeback stage with its own pipeline register, exception/ertn commit and a retire trace port.
// Build option WB_TRACE_FIFO_EN: buffer trace records in a TRACE_DEPTH-entry FIFO with consumer back-pressure.
module wb_stage_buf #(
  parameter int TRACE_DEPTH = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             resetn,

  input  logic             in_valid,
  output logic             in_allow,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_result,
  input  logic [31:0]      in_vaddr,
  input  logic             in_rf_we,
  input  logic [4:0]       in_rf_waddr,
  input  logic             in_res_from_csr,
  input  logic             in_ertn,
  input  logic [15:0]      in_ebus,
  input  logic [31:0]      csr_rvalue,

  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,

  output logic             byp_valid,
  output logic [4:0]       byp_waddr,
  output logic [31:0]      byp_wdata,

  output logic             wb_ex,
  output logic [5:0]       wb_ecode,
  output logic [8:0]       wb_esubcode,
  output logic [31:0]      wb_pc,
  output logic [31:0]      wb_vaddr,
  output logic             ertn_flush,

  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [31:0]      trace_pc,
  output logic [3:0]       trace_we,
  output logic [4:0]       trace_wnum,
  output logic [31:0]      trace_wdata,

  output logic [CNT_W-1:0] retire_cnt
);

  // Exception bus layout, listed in commit priority order (mirrors macro.vh EBUS_*).
  localparam int EBUS_INT  = 0;
  localparam int EBUS_ADEF = 1;
  localparam int EBUS_TLBR = 2;
  localparam int EBUS_PIF  = 3;
  localparam int EBUS_PPI  = 4;
  localparam int EBUS_IPE  = 5;
  localparam int EBUS_SYS  = 6;
  localparam int EBUS_BRK  = 7;
  localparam int EBUS_INE  = 8;
  localparam int EBUS_FPD  = 9;
  localparam int EBUS_FPE  = 10;
  localparam int EBUS_ALE  = 11;
  localparam int EBUS_ADEM = 12;
  localparam int EBUS_PIL  = 13;
  localparam int EBUS_PIS  = 14;
  localparam int EBUS_PME  = 15;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_IPE  = 6'h0E;
  localparam logic [5:0] ECODE_FPD  = 6'h0F;
  localparam logic [5:0] ECODE_FPE  = 6'h12;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

  logic        wb_valid;
  logic [31:0] wb_pc_reg;
  logic [31:0] wb_result;
  logic [31:0] wb_vaddr_reg;
  logic        wb_rf_we;
  logic [4:0]  wb_rf_waddr;
  logic        wb_res_from_csr;
  logic        wb_ertn;
  logic [15:0] wb_ebus;

  logic        has_ex;
  logic        stall;
  logic        wb_go;
  logic        flush;
  logic        retire;
  logic        accept;
  logic [31:0] wdata_sel;
  logic [5:0]  ecode_sel;
  logic [8:0]  esub_sel;

  assign has_ex    = |wb_ebus;
  assign wb_go     = wb_valid && !stall;
  assign flush     = wb_go && (has_ex || wb_ertn);
  assign retire    = wb_go && !has_ex;
  assign in_allow  = (!wb_valid || wb_go) && !flush;
  assign accept    = in_valid && in_allow;
  assign wdata_sel = wb_res_from_csr ? csr_rvalue : wb_result;

  // A flush kills the WB entry and any beat MEM offered in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wb_valid        <= 1'b0;
      wb_pc_reg       <= '0;
      wb_result       <= '0;
      wb_vaddr_reg    <= '0;
      wb_rf_we        <= 1'b0;
      wb_rf_waddr     <= '0;
      wb_res_from_csr <= 1'b0;
      wb_ertn         <= 1'b0;
      wb_ebus         <= '0;
    end else begin
      if (flush)
        wb_valid <= 1'b0;
      else if (accept)
        wb_valid <= 1'b1;
      else if (wb_go)
        wb_valid <= 1'b0;

      if (accept) begin
        wb_pc_reg       <= in_pc;
        wb_result       <= in_result;
        wb_vaddr_reg    <= in_vaddr;
        wb_rf_we        <= in_rf_we;
        wb_rf_waddr     <= in_rf_waddr;
        wb_res_from_csr <= in_res_from_csr;
        wb_ertn         <= in_ertn;
        wb_ebus         <= in_ebus;
      end
    end
  end

  always_comb begin
    ecode_sel = 6'h00;
    esub_sel  = 9'h000;
    if      (wb_ebus[EBUS_INT])  ecode_sel = ECODE_INT;
    else if (wb_ebus[EBUS_ADEF]) ecode_sel = ECODE_ADE;
    else if (wb_ebus[EBUS_TLBR]) ecode_sel = ECODE_TLBR;
    else if (wb_ebus[EBUS_PIF])  ecode_sel = ECODE_PIF;
    else if (wb_ebus[EBUS_PPI])  ecode_sel = ECODE_PPI;
    else if (wb_ebus[EBUS_IPE])  ecode_sel = ECODE_IPE;
    else if (wb_ebus[EBUS_SYS])  ecode_sel = ECODE_SYS;
    else if (wb_ebus[EBUS_BRK])  ecode_sel = ECODE_BRK;
    else if (wb_ebus[EBUS_INE])  ecode_sel = ECODE_INE;
    else if (wb_ebus[EBUS_FPD])  ecode_sel = ECODE_FPD;
    else if (wb_ebus[EBUS_FPE])  ecode_sel = ECODE_FPE;
    else if (wb_ebus[EBUS_ALE])  ecode_sel = ECODE_ALE;
    else if (wb_ebus[EBUS_ADEM]) begin
      ecode_sel = ECODE_ADE;
      esub_sel  = ESUBCODE_ADEM;
    end
    else if (wb_ebus[EBUS_PIL])  ecode_sel = ECODE_PIL;
    else if (wb_ebus[EBUS_PIS])  ecode_sel = ECODE_PIS;
    else if (wb_ebus[EBUS_PME])  ecode_sel = ECODE_PME;
  end

  assign wb_ex       = wb_go && has_ex;
  assign wb_ecode    = ecode_sel;
  assign wb_esubcode = esub_sel;
  assign wb_pc       = wb_pc_reg;
  assign wb_vaddr    = wb_vaddr_reg;
  assign ertn_flush  = wb_go && wb_ertn && !has_ex;

  assign rf_we    = retire && wb_rf_we;
  assign rf_waddr = wb_rf_waddr;
  assign rf_wdata = wdata_sel;

  // Bypass is offered while the result waits on trace back-pressure, so ID need not stall.
  assign byp_valid = wb_valid && wb_rf_we && !has_ex;
  assign byp_waddr = wb_rf_waddr;
  assign byp_wdata = wdata_sel;

  always_ff @(posedge clk) begin
    if (!resetn)
      retire_cnt <= '0;
    else if (retire)
      retire_cnt <= retire_cnt + CNT_W'(1);
  end

`ifdef WB_TRACE_FIFO_EN
  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(TRACE_DEPTH);

  logic [31:0]      fifo_pc    [TRACE_DEPTH];
  logic             fifo_we    [TRACE_DEPTH];
  logic [4:0]       fifo_wnum  [TRACE_DEPTH];
  logic [31:0]      fifo_wdata [TRACE_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_full;
  logic             push;
  logic             pop;

  assign fifo_full   = (count == DEPTH_C);
  assign trace_valid = (count != '0);
  assign pop         = trace_valid && trace_ready;
  assign push        = retire;
  // A pop in the same cycle frees the slot, so a full FIFO only stalls without one.
  assign stall       = wb_valid && !has_ex && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count <= count + (PTR_W+1)'(1);
      else if (pop && !push)
        count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= wb_pc_reg;
      fifo_we[wr_ptr]    <= wb_rf_we;
      fifo_wnum[wr_ptr]  <= wb_rf_waddr;
      fifo_wdata[wr_ptr] <= wdata_sel;
    end
  end

  // Storage is not reset, so gate the head with trace_valid to present zeros when empty.
  assign trace_pc    = trace_valid ? fifo_pc[rd_ptr]         : '0;
  assign trace_we    = trace_valid ? {4{fifo_we[rd_ptr]}}    : '0;
  assign trace_wnum  = trace_valid ? fifo_wnum[rd_ptr]       : '0;
  assign trace_wdata = trace_valid ? fifo_wdata[rd_ptr]      : '0;
`else
  logic unused_trace_ready;

  assign unused_trace_ready = trace_ready ^ (TRACE_DEPTH > 1);
  assign stall       = 1'b0;
  assign trace_valid = rf_we;
  assign trace_pc    = wb_pc_reg;
  assign trace_we    = {4{rf_we}};
  assign trace_wnum  = wb_rf_waddr;
  assign trace_wdata = wdata_sel;
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
// Directed bench for wb_stage_buf: vector table for the commit path plus hand sequences for trace and reset.
module tb_wb_stage_buf;

  localparam int EBUS_ALE  = 11;
  localparam int EBUS_ADEM = 12;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid;
  logic        in_allow;
  logic [31:0] in_pc, in_result, in_vaddr;
  logic        in_rf_we;
  logic [4:0]  in_rf_waddr;
  logic        in_res_from_csr;
  logic        in_ertn;
  logic [15:0] in_ebus;
  logic [31:0] csr_rvalue;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        byp_valid;
  logic [4:0]  byp_waddr;
  logic [31:0] byp_wdata;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr;
  logic        ertn_flush;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [3:0]  trace_we;
  logic [4:0]  trace_wnum;
  logic [31:0] trace_wdata;
  logic [31:0] retire_cnt;

  always #5 clk = ~clk;

  wb_stage_buf #(.TRACE_DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_allow(in_allow),
    .in_pc(in_pc), .in_result(in_result), .in_vaddr(in_vaddr),
    .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_res_from_csr(in_res_from_csr), .in_ertn(in_ertn), .in_ebus(in_ebus),
    .csr_rvalue(csr_rvalue),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .byp_valid(byp_valid), .byp_waddr(byp_waddr), .byp_wdata(byp_wdata),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_we(trace_we), .trace_wnum(trace_wnum),
    .trace_wdata(trace_wdata), .retire_cnt(retire_cnt)
  );

  typedef struct packed {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] res;
    logic [4:0]  wa;
    logic        we;
    logic        csr_sel;
    logic        ertn;
    logic [15:0] eb;
    logic [31:0] csr;
    logic        e_allow;
    logic        e_rf_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_ex;
    logic [5:0]  e_ec;
    logic [8:0]  e_es;
    logic        e_ertn;
    logic        e_byp;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trc_t;

  vec_t vecs[$];
  trc_t got_q[$];
  trc_t exp_q[$];
  int   n_vectors = 0;
  int   n_miscompares = 0;
  bit   mon_on = 1'b0;

  function automatic vec_t mk(
    input logic iv, input logic [31:0] pc, input logic [31:0] res, input logic [4:0] wa,
    input logic we, input logic csr_sel, input logic ertn, input logic [15:0] eb,
    input logic [31:0] csr, input logic e_allow, input logic e_rf_we, input logic [4:0] e_wa,
    input logic [31:0] e_wd, input logic e_ex, input logic [5:0] e_ec, input logic [8:0] e_es,
    input logic e_ertn, input logic e_byp, input logic [31:0] e_cnt);
    vec_t v;
    v.iv = iv; v.pc = pc; v.res = res; v.wa = wa; v.we = we; v.csr_sel = csr_sel;
    v.ertn = ertn; v.eb = eb; v.csr = csr; v.e_allow = e_allow; v.e_rf_we = e_rf_we;
    v.e_wa = e_wa; v.e_wd = e_wd; v.e_ex = e_ex; v.e_ec = e_ec; v.e_es = e_es;
    v.e_ertn = e_ertn; v.e_byp = e_byp; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    in_valid        = v.iv;
    in_pc           = v.pc;
    in_result       = v.res;
    in_vaddr        = v.pc ^ 32'hFFFF_0000;
    in_rf_we        = v.we;
    in_rf_waddr     = v.wa;
    in_res_from_csr = v.csr_sel;
    in_ertn         = v.ertn;
    in_ebus         = v.eb;
    csr_rvalue      = v.csr;
  endtask

  // Register address/data only matter when a write commits; ecode/esubcode only on an exception.
  task automatic check_output(input int idx, input vec_t v);
    logic [95:0] act, exp;
    act = {in_allow, rf_we, wb_ex, ertn_flush, byp_valid, retire_cnt,
           v.e_rf_we ? rf_waddr : 5'd0, v.e_rf_we ? rf_wdata : 32'd0,
           v.e_ex ? wb_ecode : 6'd0, v.e_ex ? wb_esubcode : 9'd0, 6'd0};
    exp = {v.e_allow, v.e_rf_we, v.e_ex, v.e_ertn, v.e_byp, v.e_cnt,
           v.e_rf_we ? v.e_wa : 5'd0, v.e_rf_we ? v.e_wd : 32'd0,
           v.e_ex ? v.e_ec : 6'd0, v.e_ex ? v.e_es : 9'd0, 6'd0};
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL vector %0d: got %h, expected %h", idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    apply_stimulus(mk(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0,
                      1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 9'h0, 1'b0, 1'b0, 32'h0));
  endtask

  task automatic drive_op(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] wa);
    apply_stimulus(mk(1'b1, pc, res, wa, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0,
                      1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 9'h0, 1'b0, 1'b0, 32'h0));
  endtask

  always @(negedge clk) begin
    if (mon_on && trace_valid && trace_ready)
      got_q.push_back({trace_pc, trace_we, trace_wnum, trace_wdata});
  end

  initial begin
    bit          c;
    logic [15:0] eb_both, eb_adem;
    eb_both = '0;
    eb_both[EBUS_ALE] = 1'b1;
    eb_both[EBUS_ADEM] = 1'b1;
    eb_adem = '0;
    eb_adem[EBUS_ADEM] = 1'b1;

    // Back-to-back ALU stream r1..r8, each commits one cycle after acceptance.
    for (int k = 0; k < 10; k++) begin
      c = (k >= 1 && k <= 8);
      vecs.push_back(mk(k < 8, 32'h1000 + 32'(4*k), 32'h100 + 32'(k), 5'(k+1), k < 8, 1'b0, 1'b0,
                        16'h0, 32'h0, 1'b1, c, 5'(k), 32'h100 + 32'(k) - 32'h1, 1'b0, 6'h0, 9'h0,
                        1'b0, c, (k == 0) ? 32'd0 : 32'(k-1)));
      if (k < 8)
        exp_q.push_back({32'h1000 + 32'(4*k), 4'hF, 5'(k+1), 32'h100 + 32'(k)});
    end
    // ALE+ADEM: ALE wins; then ADEM alone with a younger op that must be discarded.
    vecs.push_back(mk(1'b1, 32'h2000, 32'h0, 5'd20, 1'b1, 1'b0, 1'b0, eb_both, 32'h0,
                      1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 9'h0, 1'b0, 1'b0, 32'd8));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0,
                      1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 6'h09, 9'h0, 1'b0, 1'b0, 32'd8));
    vecs.push_back(mk(1'b1, 32'h2004, 32'h0, 5'd21, 1'b1, 1'b0, 1'b0, eb_adem, 32'h0,
                      1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 9'h0, 1'b0, 1'b0, 32'd8));
    vecs.push_back(mk(1'b1, 32'h2008, 32'h999, 5'd22, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0,
                      1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 6'h08, 9'h001, 1'b0, 1'b0, 32'd8));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0,
                      1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 9'h0, 1'b0, 1'b0, 32'd8));
    // CSR read result selects csr_rvalue over the ALU result.
    vecs.push_back(mk(1'b1, 32'h3000, 32'h1, 5'd10, 1'b1, 1'b1, 1'b0, 16'h0, 32'hDEADBEEF,
                      1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 9'h0, 1'b0, 1'b0, 32'd8));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'hDEADBEEF,
                      1'b1, 1'b1, 5'd10, 32'hDEADBEEF, 1'b0, 6'h0, 9'h0, 1'b0, 1'b1, 32'd8));
    exp_q.push_back({32'h3000, 4'hF, 5'd10, 32'hDEADBEEF});
    // ertn with a younger instruction behind it.
    vecs.push_back(mk(1'b1, 32'h4000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0,
                      1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 9'h0, 1'b0, 1'b0, 32'd9));
    vecs.push_back(mk(1'b1, 32'h4004, 32'h777, 5'd11, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0,
                      1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 9'h0, 1'b1, 1'b0, 32'd9));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0,
                      1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 9'h0, 1'b0, 1'b0, 32'd10));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0,
                      1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 9'h0, 1'b0, 1'b0, 32'd10));
`ifdef WB_TRACE_FIFO_EN
    exp_q.push_back({32'h4000, 4'h0, 5'd0, 32'h0});
`endif

    drive_idle();
    trace_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_in_allow", 32'(in_allow), 32'd1);
    check_val("reset_rf_we", 32'(rf_we), 32'd0);
    check_val("reset_retire_cnt", retire_cnt, 32'd0);
    check_val("reset_trace_valid", 32'(trace_valid), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    mon_on = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      trace_ready = 1'b1;
      @(negedge clk);
      check_output(i, vecs[i]);
      @(posedge clk);
      #1;
    end
    mon_on = 1'b0;

    check_val("trace_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        n_vectors++;
        if (got_q[i] !== exp_q[i]) begin
          n_miscompares++;
          $display("[TB] FAIL trace_rec %0d: got %h, expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end

`ifdef WB_TRACE_FIFO_EN
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_op(32'h5000 + 32'(4*i), 32'h500 + 32'(i), 5'(12+i));
      @(negedge clk);
      if (i == 1) begin
        check_val("fill_commit_i0", 32'(rf_we), 32'd1);
        check_val("fill_no_fallthrough", 32'(trace_valid), 32'd0);
      end
      if (i == 2)
        check_val("fill_head_pc", trace_pc, 32'h5000);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 2; i++) begin
      drive_op(32'h5014, 32'h505, 5'd17);
      @(negedge clk);
      check_val("stall_in_allow", 32'(in_allow), 32'd0);
      check_val("stall_rf_we", 32'(rf_we), 32'd0);
      check_val("stall_byp_valid", 32'(byp_valid), 32'd1);
      check_val("stall_byp_waddr", 32'(byp_waddr), 32'd16);
      check_val("stall_trace_pc", trace_pc, 32'h5000);
      @(posedge clk);
      #1;
    end
    trace_ready = 1'b1;
    @(negedge clk);
    check_val("pop_commit_rf_we", 32'(rf_we), 32'd1);
    check_val("pop_commit_waddr", 32'(rf_waddr), 32'd16);
    check_val("pop_commit_wdata", rf_wdata, 32'h504);
    check_val("pop_commit_in_allow", 32'(in_allow), 32'd1);
    @(posedge clk);
    #1;
    trace_ready = 1'b0;
    drive_idle();
    @(negedge clk);
    check_val("restall_rf_we", 32'(rf_we), 32'd0);
    check_val("restall_in_allow", 32'(in_allow), 32'd0);
    check_val("restall_head_pc", trace_pc, 32'h5004);
    check_val("restall_retire_cnt", retire_cnt, 32'd15);
    @(posedge clk);
    #1;
`else
    trace_ready = 1'b0;
    drive_op(32'h6000, 32'h600, 5'd5);
    @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    check_val("legacy_rf_we", 32'(rf_we), 32'd1);
    check_val("legacy_in_allow", 32'(in_allow), 32'd1);
    check_val("legacy_trace_valid", 32'(trace_valid), 32'd1);
    check_val("legacy_trace_pc", trace_pc, 32'h6000);
    check_val("legacy_trace_we", 32'(trace_we), 32'hF);
    check_val("legacy_trace_wnum", 32'(trace_wnum), 32'd5);
    check_val("legacy_trace_wdata", trace_wdata, 32'h600);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("legacy_retire_cnt", retire_cnt, 32'd11);
    check_val("legacy_trace_idle", 32'(trace_valid), 32'd0);
    @(posedge clk);
    #1;
`endif

    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check_val("midreset_trace_valid", 32'(trace_valid), 32'd0);
    check_val("midreset_retire_cnt", retire_cnt, 32'd0);
    check_val("midreset_in_allow", 32'(in_allow), 32'd1);
    check_val("midreset_rf_we", 32'(rf_we), 32'd0);
    check_val("midreset_byp_valid", 32'(byp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
